// File: rtl/time_display_pkg.sv
// time_display_pkg: digit slot map and 7-segment codes (gfedcba, active-high) for the time display scanner.
package time_display_pkg;
    typedef logic [2:0] digit_idx_t;
    localparam digit_idx_t DIG_HT = 3'd0;
    localparam digit_idx_t DIG_HU = 3'd1;
    localparam digit_idx_t DIG_MT = 3'd2;
    localparam digit_idx_t DIG_MU = 3'd3;
    localparam digit_idx_t DIG_ST = 3'd4;
    localparam digit_idx_t DIG_SU = 3'd5;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d > 4'd9) ? SEG_OFF : SEG_DIGIT[d];
    endfunction
endpackage

// File: rtl/time_display_scan_bin2bcd.sv
// bin2bcd_2digit: combinational 0..63 to two BCD digits by compare-subtract, with a field range flag.
module bin2bcd_2digit (
    input  logic [5:0] i_value,
    input  logic [5:0] i_limit,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_oor
);
    logic [5:0] w_r1, w_r2;
    always_comb begin
        w_r1    = (i_value >= 6'd40) ? i_value - 6'd40 : i_value;
        w_r2    = (w_r1 >= 6'd20) ? w_r1 - 6'd20 : w_r1;
        o_tens  = {1'b0, i_value >= 6'd40, w_r1 >= 6'd20, w_r2 >= 6'd10};
        o_units = 4'((w_r2 >= 6'd10) ? w_r2 - 6'd10 : w_r2);
        o_oor   = i_value >= i_limit;
    end
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: multiplexed 6-digit HH.MM.SS 7-segment driver with per-frame time snapshot.
// Optional ALARM_BLINK_EN: blinks the whole display while the snapshot buzzer flag is set.
module time_display_scan
    import time_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic       buzzer,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] r_cnt;
    digit_idx_t    r_idx;
    logic [4:0]    r_hours;
    logic [5:0]    r_mins, r_secs;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [5:0]    r_an;
    logic          w_tick, w_wrap, w_on, w_dash, w_dp;
    logic          w_h_oor, w_m_oor, w_s_oor;
    logic [3:0]    w_ht, w_hu, w_mt, w_mu, w_st, w_su, w_bcd;
    logic [6:0]    w_code;

    bin2bcd_2digit u_hours (.i_value({1'b0, r_hours}), .i_limit(6'd24), .o_tens(w_ht), .o_units(w_hu), .o_oor(w_h_oor));
    bin2bcd_2digit u_mins  (.i_value(r_mins), .i_limit(6'd60), .o_tens(w_mt), .o_units(w_mu), .o_oor(w_m_oor));
    bin2bcd_2digit u_secs  (.i_value(r_secs), .i_limit(6'd60), .o_tens(w_st), .o_units(w_su), .o_oor(w_s_oor));

    assign w_tick = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_wrap = w_tick && r_idx == DIG_SU;
    assign w_dp   = r_idx == DIG_HU || r_idx == DIG_MU;

    always_comb begin
        w_bcd  = 4'd0;
        w_dash = 1'b0;
        case (r_idx)
            DIG_HT:  begin w_bcd = w_ht; w_dash = w_h_oor; end
            DIG_HU:  begin w_bcd = w_hu; w_dash = w_h_oor; end
            DIG_MT:  begin w_bcd = w_mt; w_dash = w_m_oor; end
            DIG_MU:  begin w_bcd = w_mu; w_dash = w_m_oor; end
            DIG_ST:  begin w_bcd = w_st; w_dash = w_s_oor; end
            DIG_SU:  begin w_bcd = w_su; w_dash = w_s_oor; end
            default: w_bcd = 4'hF;
        endcase
        w_code = w_dash ? SEG_DASH : seg_of(w_bcd);
    end

    // The tick loads the current slot's digit; the enable drops one cycle before the next tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= DIG_HT;
            r_hours <= '0;
            r_mins  <= '0;
            r_secs  <= '0;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b0;
            r_an    <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick) begin
                r_idx <= (r_idx >= DIG_SU) ? DIG_HT : r_idx + 3'd1;
                r_seg <= w_code;
                r_dp  <= w_dp;
                r_an  <= w_on ? 6'(1) << r_idx : '0;
            end else if (r_cnt == CW'(REFRESH_DIV - 2)) begin
                r_an  <= '0;
            end
            if (w_wrap) begin
                r_hours <= hours;
                r_mins  <= mins;
                r_secs  <= secs;
            end
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_wrap) begin
            if (!buzzer) begin
                r_fcnt  <= '0;
                r_phase <= 1'b1;
            end else if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + FW'(1);
            end
        end
    end
    assign w_on = r_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = buzzer | (BLINK_FRAMES < 1);
    assign w_on = 1'b1;
`endif

    assign seg = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dp  = (ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign an  = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: random and directed stimulus against a cycle-position reference model of the scanner.
module tb_time_display_scan;
    localparam int DIV = 4;
    localparam int BF  = 2;
    localparam int FR  = 6 * DIV;
    localparam logic [6:0] SEGTAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] hours = '0;
    logic [5:0] mins = '0;
    logic [5:0] secs = '0;
    logic       buzzer = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int n_chk = 0;
    int n_pass = 0;
    int n;
    int run;
    int f_h [0:1023];
    int f_m [0:1023];
    int f_s [0:1023];
    bit f_lit [0:1023];
    bit done = 1'b0;

    time_display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .hours(hours), .mins(mins), .secs(secs),
        .buzzer(buzzer), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
    endtask

    // n counts edges since reset release; every FR edges a new frame's snapshot is taken.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0;
            run <= 0;
            f_h[0] <= 0;
            f_m[0] <= 0;
            f_s[0] <= 0;
            f_lit[0] <= 1'b1;
        end else begin
            n <= n + 1;
            if ((n + 1) % FR == 0) begin
                f_h[((n + 1) / FR) % 1024] <= int'(hours);
                f_m[((n + 1) / FR) % 1024] <= int'(mins);
                f_s[((n + 1) / FR) % 1024] <= int'(secs);
                run <= buzzer ? run + 1 : 0;
                f_lit[((n + 1) / FR) % 1024] <= buzzer ? (((run + 1) / BF) % 2 == 0) : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!done) begin
            int s, p, d, f, v, lim;
            bit lit;
            logic [6:0] code, es;
            logic [5:0] ea;
            logic ed;
            s = n / DIV;
            p = n % DIV;
            if (reset || s == 0) begin
                es = 7'h7F;
                ea = 6'h3F;
                ed = 1'b1;
            end else begin
                d = (s - 1) % 6;
                f = ((s - 1) / 6) % 1024;
                v   = (d < 2) ? f_h[f] : (d < 4) ? f_m[f] : f_s[f];
                lim = (d < 2) ? 24 : 60;
                code = (v >= lim) ? 7'h40 : SEGTAB[(d % 2 == 0) ? v / 10 : v % 10];
`ifdef ALARM_BLINK_EN
                lit = f_lit[f];
`else
                lit = 1'b1;
`endif
                es = ~code;
                ed = !(d == 1 || d == 3);
                ea = (p == DIV - 1 || !lit) ? 6'h3F : ~(6'(1) << d);
            end
            check("seg", 32'(seg), 32'(es));
            check("an", 32'(an), 32'(ea));
            check("dp", 32'(dp), 32'(ed));
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        cycles(3);
        reset = 1'b0;
        hours = 5'd13; mins = 6'd45; secs = 6'd7;
        cycles(FR + 10);
        secs = 6'd8;
        cycles(2 * FR);
        cycles(7);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        hours = 5'd24; mins = 6'd60; secs = 6'd33;
        cycles(3 * FR);
        hours = 5'd23; mins = 6'd59; secs = 6'd59; buzzer = 1'b1;
        cycles(9 * FR);
        buzzer = 1'b0;
        cycles(3 * FR);
        for (int i = 0; i < 80; i++) begin
            hours  = 5'($urandom_range(0, 31));
            mins   = 6'($urandom_range(0, 63));
            secs   = 6'($urandom_range(0, 63));
            buzzer = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 2));
                reset = 1'b0;
            end
            cycles($urandom_range(1, 3 * FR));
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
